// File: rtl/speck_controller_if.sv
// Host-side handshake bundle for the SPECK128/128 controller: block input
// (key + plaintext) and ciphertext output, each with valid/ready.
interface speck_controller_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid, key, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, key, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/speck_controller.sv
// Iterative SPECK128/128 encryptor: one round per clock, with the round key
// expanded on the fly alongside the data path. Result is held until taken.
module speck_controller #(
  parameter int ROUNDS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  speck_controller_if.slave   bus,
  output logic                busy,
  output logic [4:0]          round_idx,
  output logic [1:0]          state_response
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t         state_reg, state_next;
  logic [63:0]    x_reg, x_next, y_reg, y_next;
  logic [63:0]    k_reg, k_next, l_reg, l_next;
  logic [4:0]     cnt_reg, cnt_next;
  logic [127:0]   ct_reg, ct_next;

  logic [63:0]    x_rnd, y_rnd, k_rnd, l_rnd;

  function automatic logic [63:0] ror8(input logic [63:0] v);
    return {v[7:0], v[63:8]};
  endfunction

  function automatic logic [63:0] rol3(input logic [63:0] v);
    return {v[60:0], v[63:61]};
  endfunction

  // Data round uses the current k; the schedule produces the next k in parallel.
  always_comb begin
    x_rnd = (ror8(x_reg) + y_reg) ^ k_reg;
    y_rnd = rol3(y_reg) ^ x_rnd;
    l_rnd = (k_reg + ror8(l_reg)) ^ {59'd0, cnt_reg};
    k_rnd = rol3(k_reg) ^ l_rnd;
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    k_next     = k_reg;
    l_next     = l_reg;
    cnt_next   = cnt_reg;
    ct_next    = ct_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          x_next     = bus.plaintext[127:64];
          y_next     = bus.plaintext[63:0];
          k_next     = bus.key[63:0];
          l_next     = bus.key[127:64];
          cnt_next   = 5'd0;
          state_next = ROUND;
        end
      end
      ROUND: begin
        x_next = x_rnd;
        y_next = y_rnd;
        if (cnt_reg == LAST) begin
          // Final round: no further key needed, capture the result for output.
          ct_next    = {x_rnd, y_rnd};
          state_next = DONE;
        end else begin
          k_next   = k_rnd;
          l_next   = l_rnd;
          cnt_next = cnt_reg + 5'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      k_reg     <= '0;
      l_reg     <= '0;
      cnt_reg   <= '0;
      ct_reg    <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      k_reg     <= k_next;
      l_reg     <= l_next;
      cnt_reg   <= cnt_next;
      ct_reg    <= ct_next;
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.ciphertext  = ct_reg;
  assign busy            = (state_reg == ROUND);
  assign round_idx       = (state_reg == ROUND) ? cnt_reg : 5'd0;
  assign state_response  = state_reg;

endmodule
